vga_axil_slave: RTL and testbench
=================================

// Module: vga_axil_slave
// PURPOSE
//  AXI4-Lite slave front-end for the VGA IP register file. Accepts AW/W/AR from the interconnect,
//  arbitrates reads vs writes onto one native register port (req/ack), returns B/R responses.
//  Sits between the SoC AXI-Lite fabric and the VGA control/status register bank.
// PARAMETERS
//  NUM_REGS        16   native word locations; native addr >= NUM_REGS -> SLVERR, no native access
//  TIMEOUT_CYCLES  255  max cycles native_req_o waits for native_ack_i; 0 = wait forever
// PORTS
//  clk_i            in   1   clock
//  arst_ni          in   1   asynchronous active-low reset
//  s_awaddr_i       in   32  write address (axil_addr_t)
//  s_awvalid_i/s_awready_o  in/out 1  AW handshake
//  s_wdata_i        in   32  write data (axil_data_t)
//  s_wstrb_i        in   4   byte strobes
//  s_wvalid_i/s_wready_o    in/out 1  W handshake
//  s_bresp_o        out  2   write response (axil_resp_e)
//  s_bvalid_o/s_bready_i    out/in 1  B handshake
//  s_araddr_i       in   32  read address
//  s_arvalid_i/s_arready_o  in/out 1  AR handshake
//  s_rdata_o        out  32  read data
//  s_rresp_o        out  2   read response
//  s_rvalid_o/s_rready_i    out/in 1  R handshake
//  native_req_o     out  1   native access request, held until ack or timeout
//  native_we_o      out  1   1 = write, 0 = read
//  native_addr_o    out  29  native_addr_t, = axil2native_addr(axaddr)
//  native_wdata_o   out  32  write data;  native_be_o  out  4  byte enables (= wstrb)
//  native_rdata_i   in   32  read data, valid with ack;  native_err_i  in  1  error, valid with ack
//  native_ack_i     in   1   access complete; ignored when native_req_o = 0
// BEHAVIOUR
//  Reset (arst_ni=0, async): all valid/req outputs 0; aw/w/arready 1; resp OKAY; data/addr 0;
//   arbiter pointer = write; timeout counter 0. Reset mid-transaction drops it, no B/R issued.
//  Write FSM W_IDLE->W_REQ->W_RESP->W_IDLE. In W_IDLE AW and W captured independently (either
//   order/same cycle); each ready drops after its own handshake. Both captured -> pending write.
//  Read FSM R_IDLE->R_REQ->R_RESP->R_IDLE. AR captured in R_IDLE; arready low until R completes.
//  One outstanding write + one outstanding read max; aw/w/arready high only in idle state.
//  Arbiter: one native access at a time. Single pending -> granted next cycle. Both pending same
//   cycle -> round-robin: grant opposite of last granted; after reset write first.
//  Grant: native_req_o rises the cycle after capture completes; addr/we/wdata/be stable while req=1.
//  Out-of-range addr: no native_req_o; go straight to RESP with SLVERR (R data 0). Addr bits [2:0]
//   ignored.
//  Ack cycle: req drops next cycle; resp = native_err_i ? SLVERR : OKAY; R captures native_rdata_i.
//  Timeout: counter counts cycles req=1 without ack; reaching TIMEOUT_CYCLES drops req, SLVERR,
//   rdata 0. Late ack afterwards ignored. Counter clears on every new grant.
//  bvalid/rvalid held, payload stable, until ready; FSM returns idle the cycle after handshake.
//  Min latency write: AW+W cycle 0 -> req cycle 1 -> ack cycle 1 -> bvalid cycle 2. Read same.
//  Other channel may keep capturing while one is in RESP; back-pressure on B never blocks R.
// STRUCTURE
//  vga_axil_pkg holds axil_addr_t/axil_data_t/axil_resp_e, native_addr_t, axil2native_addr,
//   plus new: wr_state_e, rd_state_e, axil_strb_t (AXIL_DATA_WIDTH/8).
//  Sub-module vga_axil_arb: 2-requester round-robin arbiter with native req/ack/timeout sequencing.
// TESTING
//  1 Write 0x8 data 0xDEADBEEF strb 0xF, ack 1 cycle later -> native addr 1, we=1, bresp OKAY.
//  2 W one cycle before AW, bready low 5 cycles -> bvalid held, bresp stable, single native req.
//  3 AR and AW+W same cycle after reset -> write granted first, read next; then repeat: read first.
//  4 Read addr 0x80 (native 16, NUM_REGS=16) -> no native_req_o, rresp SLVERR, rdata 0.
//  5 Read, ack never arrives, TIMEOUT_CYCLES=4 -> req drops after 4 cycles, rresp SLVERR; late ack ignored.
//  6 arst_ni low while native_req_o=1 and bvalid pending -> outputs to reset values, no B after release.

Source files
------------

// File: rtl/vga_axil_pkg.sv
// Shared types and helpers for the VGA AXI4-Lite register front-end.
package vga_axil_pkg;

    localparam int AXIL_ADDR_WIDTH   = 32;
    localparam int AXIL_DATA_WIDTH   = 32;
    localparam int AXIL_STRB_WIDTH   = AXIL_DATA_WIDTH / 8;
    localparam int NATIVE_ADDR_WIDTH = 29;

    typedef logic [AXIL_ADDR_WIDTH-1:0]   axil_addr_t;
    typedef logic [AXIL_DATA_WIDTH-1:0]   axil_data_t;
    typedef logic [AXIL_STRB_WIDTH-1:0]   axil_strb_t;
    typedef logic [NATIVE_ADDR_WIDTH-1:0] native_addr_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_RESP
    } rd_state_e;

    // Which requester owns (or will own) the native port.
    typedef enum logic {
        ARB_WR = 1'b0,
        ARB_RD = 1'b1
    } arb_sel_e;

    // Byte address to native word index; the byte offset within a word is dropped.
    function automatic native_addr_t axil2native_addr(input axil_addr_t addr);
        return native_addr_t'(addr >> 3);
    endfunction

endpackage

// File: rtl/vga_axil_arb.sv
// Two-requester round-robin arbiter that sequences one native access at a time,
// holding the request until ack or until the timeout expires.
module vga_axil_arb
    import vga_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic wr_pend_i,
    input  logic rd_pend_i,
    input  logic native_ack_i,
    input  logic native_err_i,
    output logic req_o,
    output logic owner_o,
    output logic done_o,
    output logic err_o,
    output logic timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

    logic          busy_q, busy_d;
    arb_sel_e      owner_q, owner_d;
    arb_sel_e      prio_q, prio_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Current access finishes either on ack or when it has waited the full timeout.
    always_comb begin
        done_o    = 1'b0;
        err_o     = 1'b0;
        timeout_o = 1'b0;
        if (busy_q) begin
            if (native_ack_i) begin
                done_o = 1'b1;
                err_o  = native_err_i;
            end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
                done_o    = 1'b1;
                err_o     = 1'b1;
                timeout_o = 1'b1;
            end
        end
    end

    // Grant a waiting requester as soon as the port is free; the priority pointer
    // only moves when both sides contend in the same cycle.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (busy_q && !done_o) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (busy_q && done_o) begin
            busy_d = 1'b0;
        end
        if (!busy_q || done_o) begin
            if (wr_pend_i && rd_pend_i) begin
                busy_d  = 1'b1;
                owner_d = prio_q;
                prio_d  = (prio_q == ARB_WR) ? ARB_RD : ARB_WR;
                cnt_d   = '0;
            end else if (wr_pend_i) begin
                busy_d  = 1'b1;
                owner_d = ARB_WR;
                cnt_d   = '0;
            end else if (rd_pend_i) begin
                busy_d  = 1'b1;
                owner_d = ARB_RD;
                cnt_d   = '0;
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_q  <= 1'b0;
            owner_q <= ARB_WR;
            prio_q  <= ARB_WR;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_o   = busy_q;
    assign owner_o = owner_q;

endmodule

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave front-end for the VGA register bank: captures AW/W/AR,
// funnels them through one native req/ack port and returns B/R responses.
module vga_axil_slave
    import vga_axil_pkg::*;
#(
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        arst_ni,
    input  logic [31:0] s_awaddr_i,
    input  logic        s_awvalid_i,
    output logic        s_awready_o,
    input  logic [31:0] s_wdata_i,
    input  logic [3:0]  s_wstrb_i,
    input  logic        s_wvalid_i,
    output logic        s_wready_o,
    output logic [1:0]  s_bresp_o,
    output logic        s_bvalid_o,
    input  logic        s_bready_i,
    input  logic [31:0] s_araddr_i,
    input  logic        s_arvalid_i,
    output logic        s_arready_o,
    output logic [31:0] s_rdata_o,
    output logic [1:0]  s_rresp_o,
    output logic        s_rvalid_o,
    input  logic        s_rready_i,
    output logic        native_req_o,
    output logic        native_we_o,
    output logic [28:0] native_addr_o,
    output logic [31:0] native_wdata_o,
    output logic [3:0]  native_be_o,
    input  logic [31:0] native_rdata_i,
    input  logic        native_err_i,
    input  logic        native_ack_i
);

    wr_state_e    wr_state_q, wr_state_d;
    logic         aw_have_q, aw_have_d, w_have_q, w_have_d;
    native_addr_t awaddr_q, awaddr_d;
    axil_data_t   wdata_q, wdata_d;
    axil_strb_t   wstrb_q, wstrb_d;
    axil_resp_e   bresp_q, bresp_d;

    rd_state_e    rd_state_q, rd_state_d;
    native_addr_t araddr_q, araddr_d;
    axil_data_t   rdata_q, rdata_d;
    axil_resp_e   rresp_q, rresp_d;

    logic aw_hs, w_hs, ar_hs;
    logic wr_pend, rd_pend;
    logic arb_req, arb_owner, arb_done, arb_err, arb_timeout;

    assign s_awready_o = (wr_state_q == W_IDLE) && !aw_have_q;
    assign s_wready_o  = (wr_state_q == W_IDLE) && !w_have_q;
    assign s_arready_o = (rd_state_q == R_IDLE);
    assign aw_hs       = s_awvalid_i && s_awready_o;
    assign w_hs        = s_wvalid_i && s_wready_o;
    assign ar_hs       = s_arvalid_i && s_arready_o;

    // A side asks for the native port whenever it is heading into (or staying in) its REQ state.
    assign wr_pend = (wr_state_d == W_REQ);
    assign rd_pend = (rd_state_d == R_REQ);

    // Write channel: collect AW and W in any order, then access or fail fast on a bad address.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_have_d = 1'b1;
                    awaddr_d  = axil2native_addr(s_awaddr_i);
                end
                if (w_hs) begin
                    w_have_d = 1'b1;
                    wdata_d  = s_wdata_i;
                    wstrb_d  = s_wstrb_i;
                end
                if (aw_have_d && w_have_d) begin
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    if (awaddr_d < native_addr_t'(NUM_REGS)) begin
                        wr_state_d = W_REQ;
                    end else begin
                        wr_state_d = W_RESP;
                        bresp_d    = RESP_SLVERR;
                    end
                end
            end
            W_REQ: begin
                if (arb_done && (arb_owner == ARB_WR)) begin
                    wr_state_d = W_RESP;
                    bresp_d    = arb_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
            W_RESP: begin
                if (s_bready_i) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Read channel: capture AR, access or fail fast, then hold R until accepted.
    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    araddr_d = axil2native_addr(s_araddr_i);
                    if (araddr_d < native_addr_t'(NUM_REGS)) begin
                        rd_state_d = R_REQ;
                    end else begin
                        rd_state_d = R_RESP;
                        rresp_d    = RESP_SLVERR;
                        rdata_d    = '0;
                    end
                end
            end
            R_REQ: begin
                if (arb_done && (arb_owner == ARB_RD)) begin
                    rd_state_d = R_RESP;
                    rresp_d    = arb_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d    = arb_timeout ? '0 : native_rdata_i;
                end
            end
            R_RESP: begin
                if (s_rready_i) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write channel state and captured payload.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_state_q <= W_IDLE;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read channel state and response payload.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rd_state_q <= R_IDLE;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    vga_axil_arb #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_arb (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .wr_pend_i   (wr_pend),
        .rd_pend_i   (rd_pend),
        .native_ack_i(native_ack_i),
        .native_err_i(native_err_i),
        .req_o       (arb_req),
        .owner_o     (arb_owner),
        .done_o      (arb_done),
        .err_o       (arb_err),
        .timeout_o   (arb_timeout)
    );

    assign s_bvalid_o     = (wr_state_q == W_RESP);
    assign s_bresp_o      = bresp_q;
    assign s_rvalid_o     = (rd_state_q == R_RESP);
    assign s_rresp_o      = rresp_q;
    assign s_rdata_o      = rdata_q;
    assign native_req_o   = arb_req;
    assign native_we_o    = arb_req && (arb_owner == ARB_WR);
    assign native_addr_o  = (arb_owner == ARB_RD) ? araddr_q : awaddr_q;
    assign native_wdata_o = wdata_q;
    assign native_be_o    = wstrb_q;

endmodule

// File: tb/tb_vga_axil_slave.sv
// Randomized self-checking bench for vga_axil_slave with a register-bank responder
// and a word-level reference memory.
module tb_vga_axil_slave;

    logic        clock = 1'b0;
    logic        resetN;
    logic [31:0] awAddr, wData, arAddr, rData;
    logic [3:0]  wStrb;
    logic        awValid, awReady, wValid, wReady, bValid, bReady;
    logic        arValid, arReady, rValid, rReady;
    logic [1:0]  bResp, rResp;
    logic        nReq, nWe, nAck, nErr;
    logic [28:0] nAddr;
    logic [31:0] nWdata, nRdata;
    logic [3:0]  nBe;

    int errorCount = 0;
    int checkCount = 0;

    int          ackLatency = 0;
    bit          ackNever = 1'b0;
    bit          errInject = 1'b0;
    bit          lateAck = 1'b0;
    int          reqCount = 0;
    int          reqHighCycles = 0;
    bit          grantLog[$];
    logic [28:0] addrLog[$];
    logic [31:0] bank[16];
    logic [31:0] refMem[16];

    always #5 clock = ~clock;

    vga_axil_slave #(
        .NUM_REGS(16),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clock), .arst_ni(resetN),
        .s_awaddr_i(awAddr), .s_awvalid_i(awValid), .s_awready_o(awReady),
        .s_wdata_i(wData), .s_wstrb_i(wStrb), .s_wvalid_i(wValid), .s_wready_o(wReady),
        .s_bresp_o(bResp), .s_bvalid_o(bValid), .s_bready_i(bReady),
        .s_araddr_i(arAddr), .s_arvalid_i(arValid), .s_arready_o(arReady),
        .s_rdata_o(rData), .s_rresp_o(rResp), .s_rvalid_o(rValid), .s_rready_i(rReady),
        .native_req_o(nReq), .native_we_o(nWe), .native_addr_o(nAddr),
        .native_wdata_o(nWdata), .native_be_o(nBe), .native_rdata_i(nRdata),
        .native_err_i(nErr), .native_ack_i(nAck)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Native register bank: acks after ackLatency cycles, logs every granted access.
    initial begin : responder
        bit prevReq, prevAck, newAccess, ackNow;
        int waitCnt;
        logic [3:0] idx;
        prevReq = 0; prevAck = 0; waitCnt = 0;
        nAck = 0; nErr = 0; nRdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clock);
            if (!resetN) begin
                prevReq = 0; prevAck = 0; nAck = 0; nErr = 0;
            end else begin
                newAccess = nReq && (!prevReq || prevAck);
                if (newAccess) begin
                    waitCnt = 0;
                    reqCount++;
                    grantLog.push_back(nWe);
                    addrLog.push_back(nAddr);
                end else if (nReq) begin
                    waitCnt++;
                end
                if (nReq) reqHighCycles++;
                ackNow = nReq && !ackNever && (waitCnt == ackLatency);
                nAck   = ackNow || lateAck;
                nErr   = ackNow && errInject;
                nRdata = 32'hBAD0_BAD0;
                if (ackNow) begin
                    idx = nAddr[3:0];
                    if (nWe) begin
                        if (!errInject) bank[idx] = mergeBytes(bank[idx], nWdata, nBe);
                    end else begin
                        nRdata = bank[idx];
                    end
                end
                prevReq = nReq;
                prevAck = ackNow;
            end
        end
    end

    task automatic sendAw(input logic [31:0] addr);
        int n;
        @(negedge clock);
        awAddr = addr; awValid = 1'b1; n = 0;
        while (!awReady && n < 50) begin @(negedge clock); n++; end
        checkOutput("awready", 32'(awReady), 32'd1);
        @(negedge clock);
        awValid = 1'b0;
    endtask

    task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge clock);
        wData = data; wStrb = strb; wValid = 1'b1; n = 0;
        while (!wReady && n < 50) begin @(negedge clock); n++; end
        checkOutput("wready", 32'(wReady), 32'd1);
        @(negedge clock);
        wValid = 1'b0;
    endtask

    task automatic sendAr(input logic [31:0] addr);
        int n;
        @(negedge clock);
        arAddr = addr; arValid = 1'b1; n = 0;
        while (!arReady && n < 50) begin @(negedge clock); n++; end
        checkOutput("arready", 32'(arReady), 32'd1);
        @(negedge clock);
        arValid = 1'b0;
    endtask

    task automatic waitB(input int hold, output logic [1:0] resp, output int lat);
        lat = 0;
        while (!bValid && lat < 100) begin @(negedge clock); lat++; end
        checkOutput("bvalidSeen", 32'(bValid), 32'd1);
        resp = bResp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            checkOutput("bvalidHeld", 32'(bValid), 32'd1);
            checkOutput("brespStable", 32'(bResp), 32'(resp));
        end
        bReady = 1'b1;
        @(negedge clock);
        bReady = 1'b0;
        checkOutput("bvalidDrop", 32'(bValid), 32'd0);
    endtask

    task automatic waitR(input int hold, output logic [1:0] resp, output logic [31:0] data, output int lat);
        lat = 0;
        while (!rValid && lat < 100) begin @(negedge clock); lat++; end
        checkOutput("rvalidSeen", 32'(rValid), 32'd1);
        resp = rResp;
        data = rData;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            checkOutput("rvalidHeld", 32'(rValid), 32'd1);
            checkOutput("rdataStable", rData, data);
        end
        rReady = 1'b1;
        @(negedge clock);
        rReady = 1'b0;
        checkOutput("rvalidDrop", 32'(rValid), 32'd0);
    endtask

    // Full write with expectations derived from address range, error injection and ack latency.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input int awDelay, input int wDelay,
                                 input int hold, input bit solo);
        int          idx, lat, reqBefore;
        bit          inRange;
        logic [1:0]  resp, expResp;
        logic [31:0] rd;
        idx       = int'(addr >> 3);
        inRange   = (idx < 16);
        expResp   = (!inRange || errInject) ? 2'b10 : 2'b00;
        reqBefore = reqCount;
        if (solo) reqHighCycles = 0;
        if (isWrite) begin
            fork
                begin repeat (awDelay) @(negedge clock); sendAw(addr); end
                begin repeat (wDelay) @(negedge clock); sendW(data, strb); end
            join
            waitB(hold, resp, lat);
            checkOutput("bresp", 32'(resp), 32'(expResp));
            if (inRange && !errInject) refMem[idx] = mergeBytes(refMem[idx], data, strb);
        end else begin
            sendAr(addr);
            waitR(hold, resp, rd, lat);
            checkOutput("rresp", 32'(resp), 32'(expResp));
            checkOutput("rdata", rd, inRange ? refMem[idx] : 32'd0);
        end
        if (solo) begin
            checkOutput("latency", 32'(lat), inRange ? 32'(ackLatency + 1) : 32'd0);
            checkOutput("reqCount", 32'(reqCount - reqBefore), inRange ? 32'd1 : 32'd0);
            checkOutput("reqCycles", 32'(reqHighCycles), inRange ? 32'(ackLatency + 1) : 32'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [1:0]  resp;
        logic [31:0] rd, v;
        int          lat, reqBefore, idx;
        bit          sawB, sawR;

        resetN = 1'b0;
        awAddr = 0; awValid = 0; wData = 0; wStrb = 0; wValid = 0; bReady = 0;
        arAddr = 0; arValid = 0; rReady = 0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            bank[i] = v;
            refMem[i] = v;
        end
        #1;
        checkOutput("rstAwready", 32'(awReady), 32'd1);
        checkOutput("rstWready", 32'(wReady), 32'd1);
        checkOutput("rstArready", 32'(arReady), 32'd1);
        checkOutput("rstBvalid", 32'(bValid), 32'd0);
        checkOutput("rstRvalid", 32'(rValid), 32'd0);
        checkOutput("rstReq", 32'(nReq), 32'd0);
        checkOutput("rstResp", 32'({bResp, rResp}), 32'd0);
        checkOutput("rstRdata", rData, 32'd0);
        checkOutput("rstNaddr", 32'(nAddr), 32'd0);
        repeat (3) @(negedge clock);
        resetN = 1'b1;

        $display("[TB] contention after reset: write first, then read first");
        for (int round = 0; round < 2; round++) begin
            grantLog.delete();
            fork
                applyStimulus(1'b1, 32'h18, $urandom, 4'hF, 0, 0, 0, 1'b0);
                applyStimulus(1'b0, 32'h10, 32'd0, 4'h0, 0, 0, 0, 1'b0);
            join
            checkOutput("arbGrantCount", 32'(grantLog.size()), 32'd2);
            if (grantLog.size() >= 2) begin
                checkOutput("arbFirstWe", 32'(grantLog[0]), (round == 0) ? 32'd1 : 32'd0);
                checkOutput("arbSecondWe", 32'(grantLog[1]), (round == 0) ? 32'd0 : 32'd1);
            end
        end

        $display("[TB] basic write to 0x8");
        addrLog.delete();
        grantLog.delete();
        applyStimulus(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b1);
        checkOutput("wrNativeAddr", (addrLog.size() > 0) ? 32'(addrLog[0]) : 32'hFFFF_FFFF, 32'd1);
        checkOutput("wrNativeWe", (grantLog.size() > 0) ? 32'(grantLog[0]) : 32'hFFFF_FFFF, 32'd1);
        checkOutput("bankWord1", bank[1], 32'hDEADBEEF);

        $display("[TB] W before AW with B back-pressure");
        reqBefore = reqCount;
        sendW(32'hCAFE_0123, 4'b0101);
        checkOutput("wreadyLowAfterW", 32'(wReady), 32'd0);
        checkOutput("awreadyStillHigh", 32'(awReady), 32'd1);
        sendAw(32'h2C);
        waitB(5, resp, lat);
        checkOutput("t2Bresp", 32'(resp), 32'd0);
        checkOutput("t2ReqCount", 32'(reqCount - reqBefore), 32'd1);
        refMem[5] = mergeBytes(refMem[5], 32'hCAFE_0123, 4'b0101);
        applyStimulus(1'b0, 32'h28, 32'd0, 4'h0, 0, 0, 2, 1'b1);

        $display("[TB] out-of-range read");
        applyStimulus(1'b0, 32'h80, 32'd0, 4'h0, 0, 0, 0, 1'b1);

        $display("[TB] read timeout");
        ackNever = 1'b1;
        reqHighCycles = 0;
        reqBefore = reqCount;
        sendAr(32'h10);
        waitR(0, resp, rd, lat);
        checkOutput("toRresp", 32'(resp), 32'd2);
        checkOutput("toRdata", rd, 32'd0);
        checkOutput("toReqCycles", 32'(reqHighCycles), 32'd4);
        checkOutput("toLatency", 32'(lat), 32'd4);
        lateAck = 1'b1;
        repeat (2) @(negedge clock);
        lateAck = 1'b0;
        @(negedge clock);
        checkOutput("lateAckRvalid", 32'(rValid), 32'd0);
        checkOutput("lateAckReq", 32'(nReq), 32'd0);
        checkOutput("lateAckReqCount", 32'(reqCount - reqBefore), 32'd1);
        ackNever = 1'b0;

        $display("[TB] randomized traffic");
        for (int t = 0; t < 60; t++) begin
            idx        = $urandom_range(0, 17);
            ackLatency = $urandom_range(0, 2);
            errInject  = ($urandom_range(0, 5) == 0);
            applyStimulus(1'($urandom_range(0, 1)), (32'(idx) << 3) | 32'($urandom_range(0, 7)),
                          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                          $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
        end
        errInject = 1'b0;
        ackLatency = 0;

        $display("[TB] reset during outstanding transactions");
        fork
            sendAw(32'h20);
            sendW(32'h1234_5678, 4'hF);
        join
        lat = 0;
        while (!bValid && lat < 50) begin @(negedge clock); lat++; end
        checkOutput("t6BvalidPending", 32'(bValid), 32'd1);
        ackNever = 1'b1;
        sendAr(32'h30);
        checkOutput("t6ReqActive", 32'(nReq), 32'd1);
        resetN = 1'b0;
        #1;
        checkOutput("t6Req", 32'(nReq), 32'd0);
        checkOutput("t6Bvalid", 32'(bValid), 32'd0);
        checkOutput("t6Rvalid", 32'(rValid), 32'd0);
        checkOutput("t6Readies", 32'({awReady, wReady, arReady}), 32'd7);
        checkOutput("t6Naddr", 32'(nAddr), 32'd0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        ackNever = 1'b0;
        bReady = 1'b1;
        rReady = 1'b1;
        sawB = 0;
        sawR = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            sawB |= bValid;
            sawR |= rValid;
        end
        bReady = 1'b0;
        rReady = 1'b0;
        checkOutput("t6NoBAfterReset", 32'(sawB), 32'd0);
        checkOutput("t6NoRAfterReset", 32'(sawR), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
